servo_cmd_scheduler: RTL and testbench
======================================

// Module: servo_cmd_scheduler
// PURPOSE
//  Shares the servo controller's single command bus (direction, speed_angle, servo_select)
//  between two requesters (CPU register port, colour tracker) and two servos.
//  Keeps a signed 7-bit target per servo and time-multiplexes the bus.
//  Each servo is held selected for longer than one 16 ms PWM frame, so the controller's
//  PulseCount==0 latch always sees a stable command for that servo.
// PARAMETERS
//  HOLD_CYCLES  1700000  clk cycles per select slot; must exceed PWM period (391*4096) + 391
//  SLEW_STEP    4        max |change| of applied value per slot (SERVO_SLEW_EN only)
// PORTS
//  clk            in   1  clock
//  reset          in   1  synchronous, active-high
//  cpu_valid      in   1  CPU command valid
//  cpu_ready      out  1  CPU command accepted when valid&ready
//  cpu_servo      in   1  0 = full-rotation servo, 1 = normal servo
//  cpu_dir        in   1  direction bit
//  cpu_mag        in   6  speed/angle magnitude
//  trk_valid      in   1  tracker command valid
//  trk_ready      out  1  tracker command accepted when valid&ready
//  trk_servo      in   1  as cpu_servo
//  trk_dir        in   1  as cpu_dir
//  trk_mag        in   6  as cpu_mag
//  servo_select   out  1  to servo controller
//  direction      out  1  to servo controller
//  speed_angle    out  6  to servo controller
//  slot_start     out  1  1-cycle pulse when a new slot begins
//  applied        out  2  per-servo: applied value == target
// BEHAVIOUR
//  - Reset: servo_select=0, direction=0, speed_angle=0, slot_start=0, applied=2'b11.
//    Targets and applied values = 0; slot counter = 0; cpu_ready=trk_ready=0 in the reset cycle.
//  - Targets are stored as signed 7-bit t = dir ? +mag : -mag, range -63..+63.
//    dir=0 with mag=0 and dir=1 with mag=0 both mean 0.
//  - Arbitration, every cycle after reset:
//    - cpu_ready=1 always.
//    - trk_ready = !(cpu_valid && cpu_servo==trk_servo).
//    - An accepted command writes its servo's target on the next clk edge.
//    - Same cycle, different servos: both are accepted.
//    - Same cycle, same servo: CPU wins; tracker stalls and must hold its command.
//  - Slot counter counts 0..HOLD_CYCLES-1 and wraps.
//    - At wrap, servo_select toggles and slot_start pulses for one cycle.
//    - Also at wrap, {direction, speed_angle} load from the newly selected servo's applied value.
//      Sign bit gives direction: >=0 -> 1, <0 -> 0. Magnitude is |value|.
//    - Outputs change only at the wrap edge and are constant for the whole slot.
//  - A target written mid-slot takes effect at that servo's next slot, at most 2*HOLD_CYCLES later.
//  - Target write on the wrap cycle: the write is visible to the load in that same edge
//    (write-through bypass).
//  - applied[s] = (applied value of s == target of s); updated each cycle.
//  - Reset mid-slot: counter and outputs return to reset values on the next edge.
//    Any in-flight handshake is dropped.
// CONFIGURATION
//  - SERVO_SLEW_EN defined:
//    - At each slot wrap, the selected servo's applied value moves toward its target
//      by min(|target-applied|, SLEW_STEP). Computed in 8-bit signed to avoid overflow.
//    - The value passes through 0 when direction reverses; it never overshoots.
//  - Not defined: applied value = target, copied at each slot wrap. SLEW_STEP is ignored.
// STRUCTURE
//  - Package servo_pkg: typedef servo_cmd_t {servo, dir, mag[5:0]};
//    constants SERVO_FULLROT=0, SERVO_NORMAL=1, MAG_MAX=63, PWM_PERIOD_CYCLES=1601536.
//  - One sub-module servo_slew_step: combinational next = step(applied, target, SLEW_STEP).
//    It is instantiated once, on the selected servo.
//  - Top level holds the arbiter, target regs, slot counter and output regs.
// TESTING (simulate with HOLD_CYCLES=20)
//  1. Reset, no requests
//     -> outputs 0; slot_start every 20 cycles; servo_select alternates 0,1,0.
//  2. CPU writes servo0 dir=1 mag=40 mid-slot
//     -> next slot with select=0 shows direction=1, speed_angle=40;
//     -> outputs are stable for all 20 cycles of that slot.
//  3. Same cycle: CPU servo1 mag=10, tracker servo1 mag=50
//     -> cpu accepted, trk_ready=0 for that cycle;
//     -> tracker is accepted next cycle; servo1 is finally driven with 50.
//  4. Same cycle: CPU servo0 and tracker servo1
//     -> both ready=1; both targets updated.
//  5. SERVO_SLEW_EN, SLEW_STEP=4: servo0 at +8, target -6
//     -> servo0 slot outputs (dir,mag) = (1,4), (1,0), (0,4), (0,6);
//     -> applied[0] rises in the last of those slots.
//  6. Assert reset for 1 cycle mid-slot with a held tracker request
//     -> all outputs 0 and trk_ready=0 in the reset cycle; the slot restarts at count 0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command scheduler.
// Targets and applied values are signed 7-bit: dir ? +mag : -mag, range -63..+63.
package servo_pkg;

   localparam logic SERVO_FULLROT     = 1'b0;
   localparam logic SERVO_NORMAL      = 1'b1;
   localparam int   MAG_MAX           = 63;
   localparam int   PWM_PERIOD_CYCLES = 1601536;

   typedef struct packed {
      logic       servo;
      logic       dir;
      logic [5:0] mag;
   } servo_cmd_t;

   typedef logic signed [6:0] servo_val_t;

   // Command to signed target; both encodings of zero map to 0.
   function automatic servo_val_t cmd_to_val(servo_cmd_t cmd);
      servo_val_t m;
      m = {1'b0, cmd.mag};
      return cmd.dir ? m : -m;
   endfunction

   // Magnitude of a signed value; -63 is the most negative value ever stored.
   function automatic logic [5:0] val_to_mag(servo_val_t v);
      servo_val_t a;
      a = v[6] ? -v : v;
      return a[5:0];
   endfunction

endpackage

// File: rtl/servo_slew_step.sv
// One slew step: move cur_val toward tgt_val by at most STEP, never overshooting.
// Arithmetic is done in 8-bit signed so differences up to +/-126 cannot overflow.
// STEP must lie in 1..127; a STEP of 127 always lands on the target.
module servo_slew_step
   import servo_pkg::*;
#(
   parameter int STEP = 4
) (
   input  servo_val_t cur_val,
   input  servo_val_t tgt_val,
   output servo_val_t nxt_val
);

   localparam logic signed [7:0] STEP_S = 8'(STEP);

   logic signed [7:0] cur_w;
   logic signed [7:0] tgt_w;
   logic signed [7:0] diff;
   logic signed [7:0] up_w;
   logic signed [7:0] dn_w;

   assign cur_w = {cur_val[6], cur_val};
   assign tgt_w = {tgt_val[6], tgt_val};
   assign diff  = tgt_w - cur_w;
   assign up_w  = cur_w + STEP_S;
   assign dn_w  = cur_w - STEP_S;

   // Clamp the move to STEP in either direction, otherwise land on the target.
   always_comb begin
      nxt_val = tgt_val;
      if (diff > STEP_S) begin
         nxt_val = up_w[6:0];
      end else if (diff < -STEP_S) begin
         nxt_val = dn_w[6:0];
      end
   end

endmodule

// File: rtl/servo_cmd_scheduler.sv
// Shares one servo-controller command bus between a CPU port and a colour tracker
// for two servos. Each servo is held selected for HOLD_CYCLES so the controller
// always latches a stable command for it across a full PWM frame.
// Build option: define SERVO_SLEW_EN to rate-limit the applied value by SLEW_STEP
// per slot; without it the applied value jumps to the target at each slot.
module servo_cmd_scheduler
   import servo_pkg::*;
#(
   parameter int HOLD_CYCLES = 1700000,
   parameter int SLEW_STEP   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_valid,
   output logic       cpu_ready,
   input  logic       cpu_servo,
   input  logic       cpu_dir,
   input  logic [5:0] cpu_mag,
   input  logic       trk_valid,
   output logic       trk_ready,
   input  logic       trk_servo,
   input  logic       trk_dir,
   input  logic [5:0] trk_mag,
   output logic       servo_select,
   output logic       direction,
   output logic [5:0] speed_angle,
   output logic       slot_start,
   output logic [1:0] applied
);

`ifdef SERVO_SLEW_EN
   localparam bit SLEW_EN = 1'b1;
`else
   localparam bit SLEW_EN = 1'b0;
`endif

   // Without slewing, a full-range step makes the applied value land on the target.
   localparam int STEP_EFF  = SLEW_EN ? SLEW_STEP : 2 * MAG_MAX + 1;
   localparam int CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

   servo_cmd_t cpu_cmd;
   servo_cmd_t trk_cmd;
   logic       cpu_acc;
   logic       trk_acc;

   servo_val_t tgt_q   [2];
   servo_val_t tgt_nxt [2];
   servo_val_t app_q   [2];
   servo_val_t app_step;

   logic [CW-1:0] cnt_q;
   logic          wrap;
   logic          sel_nxt;

   assign cpu_cmd = '{servo: cpu_servo, dir: cpu_dir, mag: cpu_mag};
   assign trk_cmd = '{servo: trk_servo, dir: trk_dir, mag: trk_mag};

   // CPU always wins; tracker only stalls when both address the same servo.
   assign cpu_ready = !reset;
   assign trk_ready = !reset && !(cpu_valid && (cpu_servo == trk_servo));
   assign cpu_acc   = cpu_valid && cpu_ready;
   assign trk_acc   = trk_valid && trk_ready;

   assign wrap    = (cnt_q == CNT_LAST);
   assign sel_nxt = ~servo_select;

   // Target write-through: the wrap-edge load sees a command accepted that same cycle.
   always_comb begin
      tgt_nxt = tgt_q;
      if (cpu_acc) begin
         tgt_nxt[cpu_cmd.servo] = cmd_to_val(cpu_cmd);
      end
      if (trk_acc) begin
         tgt_nxt[trk_cmd.servo] = cmd_to_val(trk_cmd);
      end
   end

   servo_slew_step #(
      .STEP (STEP_EFF)
   ) u_slew (
      .cur_val (app_q[sel_nxt]),
      .tgt_val (tgt_nxt[sel_nxt]),
      .nxt_val (app_step)
   );

   // Target registers; arbitration guarantees the two writes never hit the same servo.
   always_ff @(posedge clk) begin
      if (reset) begin
         tgt_q <= '{default: '0};
      end else begin
         tgt_q <= tgt_nxt;
      end
   end

   // Slot counter, 0..HOLD_CYCLES-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (wrap) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Bus outputs and applied values change only at the slot wrap edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         servo_select <= 1'b0;
         direction    <= 1'b0;
         speed_angle  <= '0;
         slot_start   <= 1'b0;
         app_q        <= '{default: '0};
      end else begin
         slot_start <= wrap;
         if (wrap) begin
            servo_select   <= sel_nxt;
            app_q[sel_nxt] <= app_step;
            direction      <= !app_step[6];
            speed_angle    <= val_to_mag(app_step);
         end
      end
   end

   assign applied = {app_q[1] == tgt_q[1], app_q[0] == tgt_q[0]};

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Self-checking bench for servo_cmd_scheduler with HOLD_CYCLES=20.
// An integer reference model tracks targets, applied values and slot position;
// directed scenarios pin the model with literal expectations, then random traffic runs.
module tb_servo_cmd_scheduler;
   import servo_pkg::*;

   localparam int H = 20;
   localparam int S = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cpu_valid = 1'b0, cpu_servo = 1'b0, cpu_dir = 1'b0;
   logic [5:0] cpu_mag = '0;
   logic       trk_valid = 1'b0, trk_servo = 1'b0, trk_dir = 1'b0;
   logic [5:0] trk_mag = '0;
   logic       cpu_ready, trk_ready, servo_select, direction, slot_start;
   logic [5:0] speed_angle;
   logic [1:0] applied;

   servo_cmd_scheduler #(.HOLD_CYCLES(H), .SLEW_STEP(S)) dut (
      .clk(clk), .reset(reset),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_servo(cpu_servo),
      .cpu_dir(cpu_dir), .cpu_mag(cpu_mag),
      .trk_valid(trk_valid), .trk_ready(trk_ready), .trk_servo(trk_servo),
      .trk_dir(trk_dir), .trk_mag(trk_mag),
      .servo_select(servo_select), .direction(direction), .speed_angle(speed_angle),
      .slot_start(slot_start), .applied(applied)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errs = 0;

   int m_tgt [2];
   int m_app [2];
   int m_pos, m_sel, m_dir, m_mag, m_ss;
   bit m_valid = 1'b0;
   bit seen_cpu_ready, seen_trk_ready, last_trk_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int cmd_val(bit d, int m);
      return d ? m : -m;
   endfunction

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int toward(int a, int t);
`ifdef SERVO_SLEW_EN
      if (t - a > S) return a + S;
      if (a - t > S) return a - S;
`endif
      return t;
   endfunction

   // One clock: check outputs against the model, drive inputs, check readies, advance model.
   task automatic cycle(input bit r, input bit cv, input bit cs, input bit cd, input int cm,
                        input bit tv, input bit ts, input bit td, input int tm);
      bit exp_tr;
      int nt [2];
      @(negedge clk);
      if (m_valid) begin
         chk("servo_select", servo_select, m_sel);
         chk("direction", direction, m_dir);
         chk("speed_angle", speed_angle, m_mag);
         chk("slot_start", slot_start, m_ss);
         chk("applied", applied, {30'd0, m_app[1] == m_tgt[1], m_app[0] == m_tgt[0]});
      end
      reset = r;
      cpu_valid = cv; cpu_servo = cs; cpu_dir = cd; cpu_mag = 6'(cm);
      trk_valid = tv; trk_servo = ts; trk_dir = td; trk_mag = 6'(tm);
      #1;
      exp_tr = !r && !(cv && (cs == ts));
      seen_cpu_ready = cpu_ready;
      seen_trk_ready = trk_ready;
      chk("cpu_ready", cpu_ready, !r);
      chk("trk_ready", trk_ready, exp_tr);
      @(posedge clk);
      last_trk_acc = tv && exp_tr;
      if (r) begin
         m_tgt = '{0, 0}; m_app = '{0, 0};
         m_pos = 0; m_sel = 0; m_dir = 0; m_mag = 0; m_ss = 0;
         m_valid = 1'b1;
      end else begin
         nt = m_tgt;
         if (cv) nt[cs] = cmd_val(cd, cm);
         if (tv && exp_tr) nt[ts] = cmd_val(td, tm);
         if (m_pos == H - 1) begin
            m_pos = 0;
            m_sel = 1 - m_sel;
            m_app[m_sel] = toward(m_app[m_sel], nt[m_sel]);
            m_dir = (m_app[m_sel] >= 0) ? 1 : 0;
            m_mag = iabs(m_app[m_sel]);
            m_ss = 1;
         end else begin
            m_pos++;
            m_ss = 0;
         end
         m_tgt = nt;
      end
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Idle until a slot begins with the wanted servo; n counts cycles spent.
   task automatic wait_slot(input int sel_want, output int n);
      bit got;
      got = 0;
      n = 0;
      while (!got && n < 200) begin
         idle();
         n++;
         #1;
         if (slot_start === 1'b1 && servo_select === sel_want[0]) got = 1;
      end
      chk("wait_slot_bound", got, 1);
   endtask

   function automatic int rnd_mag();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return 63;
         default: return $urandom_range(0, 63);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit r, cv, cs, cd, pv, ps, pd;
      int cm, pm;

      // Reset state
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_cpu_ready", seen_cpu_ready, 0);
      chk("rst_trk_ready", seen_trk_ready, 0);
      #1;
      chk("rst_select", servo_select, 0);
      chk("rst_direction", direction, 0);
      chk("rst_speed", speed_angle, 0);
      chk("rst_slot_start", slot_start, 0);
      chk("rst_applied", applied, 3);

      // Idle slots: pulse every 20 cycles, select alternates; value 0 drives dir=1, mag=0
      wait_slot(1, n);
      chk("t1_first_slot_len", n, 20);
      chk("t1_dir_zero", direction, 1);
      chk("t1_speed_zero", speed_angle, 0);
      wait_slot(0, n);
      chk("t1_second_slot_len", n, 20);

      // CPU writes servo0 +40 mid-slot; seen at next servo0 slot, stable 20 cycles
      repeat (5) idle();
      cycle(0, 1, 0, 1, 40, 0, 0, 0, 0);
      wait_slot(0, n);
`ifndef SERVO_SLEW_EN
      chk("t2_dir", direction, 1);
      chk("t2_speed", speed_angle, 40);
`endif
      for (int k = 0; k < 19; k++) begin
         idle();
         #1;
         chk("t2_hold_select", servo_select, 0);
         chk("t2_hold_slot_start", slot_start, 0);
`ifndef SERVO_SLEW_EN
         chk("t2_hold_speed", speed_angle, 40);
`endif
      end

      // Same servo collision on the wrap cycle: CPU wins and bypasses into the load
      cycle(0, 1, 1, 1, 10, 1, 1, 1, 50);
      chk("t3_cpu_ready", seen_cpu_ready, 1);
      chk("t3_trk_stall", seen_trk_ready, 0);
      #1;
      chk("t3_bypass_select", servo_select, 1);
`ifndef SERVO_SLEW_EN
      chk("t3_bypass_speed", speed_angle, 10);
`endif
      cycle(0, 0, 0, 0, 0, 1, 1, 1, 50);
      chk("t3_trk_accept", seen_trk_ready, 1);
      wait_slot(1, n);
`ifndef SERVO_SLEW_EN
      chk("t3_final_speed", speed_angle, 50);
`endif

      // Different servos in the same cycle: both accepted
      cycle(0, 1, 0, 0, 7, 1, 1, 0, 33);
      chk("t4_cpu_ready", seen_cpu_ready, 1);
      chk("t4_trk_ready", seen_trk_ready, 1);
      wait_slot(0, n);
`ifndef SERVO_SLEW_EN
      chk("t4_s0_dir", direction, 0);
      chk("t4_s0_speed", speed_angle, 7);
`endif
      wait_slot(1, n);
`ifndef SERVO_SLEW_EN
      chk("t4_s1_dir", direction, 0);
      chk("t4_s1_speed", speed_angle, 33);
      chk("t4_applied", applied, 3);
`endif

`ifdef SERVO_SLEW_EN
      // Slew servo0 from +8 to -6 through zero
      cycle(0, 1, 0, 1, 8, 0, 0, 0, 0);
      for (int k = 0; k < 35; k++) wait_slot(0, n);
      chk("t5_start_speed", speed_angle, 8);
      chk("t5_start_applied0", applied[0], 1);
      cycle(0, 1, 0, 0, 6, 0, 0, 0, 0);
      wait_slot(0, n);
      chk("t5_s1_dir", direction, 1); chk("t5_s1_mag", speed_angle, 4); chk("t5_s1_app", applied[0], 0);
      wait_slot(0, n);
      chk("t5_s2_dir", direction, 1); chk("t5_s2_mag", speed_angle, 0); chk("t5_s2_app", applied[0], 0);
      wait_slot(0, n);
      chk("t5_s3_dir", direction, 0); chk("t5_s3_mag", speed_angle, 4); chk("t5_s3_app", applied[0], 0);
      wait_slot(0, n);
      chk("t5_s4_dir", direction, 0); chk("t5_s4_mag", speed_angle, 6); chk("t5_s4_app", applied[0], 1);
`endif

      // Reset mid-slot while the tracker holds a stalled request
      repeat (7) idle();
      cycle(0, 1, 0, 1, 5, 1, 0, 0, 9);
      chk("t6_stall", seen_trk_ready, 0);
      cycle(1, 0, 0, 0, 0, 1, 0, 0, 9);
      chk("t6_rst_cpu_ready", seen_cpu_ready, 0);
      chk("t6_rst_trk_ready", seen_trk_ready, 0);
      #1;
      chk("t6_select", servo_select, 0);
      chk("t6_direction", direction, 0);
      chk("t6_speed", speed_angle, 0);
      chk("t6_applied", applied, 3);
      cycle(0, 0, 0, 0, 0, 1, 0, 0, 9);
      chk("t6_trk_accept", seen_trk_ready, 1);
      wait_slot(1, n);
      chk("t6_restart_len", n + 1, 20);

      // Random traffic with a tracker that holds its command until accepted
      pv = 0; ps = 0; pd = 0; pm = 0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 399) == 0);
         cv = ($urandom_range(0, 3) == 0);
         cs = $urandom_range(0, 1);
         cd = $urandom_range(0, 1);
         cm = rnd_mag();
         if (!pv || last_trk_acc) begin
            pv = ($urandom_range(0, 2) == 0);
            ps = $urandom_range(0, 1);
            pd = $urandom_range(0, 1);
            pm = rnd_mag();
         end
         cycle(r, cv, cs, cd, cm, pv, ps, pd, pm);
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
